// File: rtl/ff_bank.sv
// ---------------------------------------------------------------------------
// ff_bank -- bank of WIDTH multi-function flip-flops (D / T / JK / SR).
//
// All bits share one function selected by `mode`. Each bit has its own
// per-bit inputs `a` and `b`. A parallel load overrides the selected
// function. Reset is synchronous and active high.
//
// Parameters
//   WIDTH    number of flip-flop bits in the bank (1 is legal)
//   CNT_W    width of the optional change counter
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset
//   en         in   1      update enable (0 = hold)
//   mode       in   2      00 D, 01 T, 10 JK, 11 SR
//   a          in   WIDTH  per-bit D / T / J / S
//   b          in   WIDTH  per-bit K / R (unused in D and T modes)
//   load       in   1      parallel load strobe (beats en)
//   load_val   in   WIDTH  parallel load data
//   clr_err    in   1      clears sticky sr_err
//   q          out  WIDTH  registered state
//   qn         out  WIDTH  ~q
//   sr_err     out  1      sticky flag: SR mode saw S=R=1 on some bit
//   chg        out  1      one-cycle pulse: q changed at the last edge
//   chg_cnt    out  CNT_W  saturating count of chg pulses
//                          (only when FF_CHG_CNT_EN is defined)
//
// Build option
//   FF_CHG_CNT_EN  when defined, adds the chg_cnt port and its counter.
// ---------------------------------------------------------------------------
module ff_bank #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             sr_err,
  output logic             chg
`ifdef FF_CHG_CNT_EN
  ,
  output logic [CNT_W-1:0] chg_cnt
`endif
);

  typedef enum logic [1:0] {
    MODE_D  = 2'b00,
    MODE_T  = 2'b01,
    MODE_JK = 2'b10,
    MODE_SR = 2'b11
  } mode_e;

  mode_e mode_sel;
  assign mode_sel = mode_e'(mode);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] q_q, q_d;
  logic             sr_err_q, sr_err_d;
  logic             chg_q, chg_d;

  // Per-bit result of the selected function, and per-bit SR violation.
  logic [WIDTH-1:0] func_next;
  logic [WIDTH-1:0] sr_viol;

  // -------------------------------------------------------------------------
  // Per-bit function logic
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      always_comb begin
        func_next[gi] = q_q[gi];
        sr_viol[gi]   = 1'b0;
        unique case (mode_sel)
          MODE_D: func_next[gi] = a[gi];
          MODE_T: func_next[gi] = q_q[gi] ^ a[gi];
          MODE_JK: begin
            unique case ({a[gi], b[gi]})
              2'b00: func_next[gi] = q_q[gi];
              2'b01: func_next[gi] = 1'b0;
              2'b10: func_next[gi] = 1'b1;
              2'b11: func_next[gi] = ~q_q[gi];
            endcase
          end
          MODE_SR: begin
            unique case ({a[gi], b[gi]})
              2'b00: func_next[gi] = q_q[gi];
              2'b01: func_next[gi] = 1'b0;
              2'b10: func_next[gi] = 1'b1;
              // Invalid S=R=1: this bit holds, the bank flags the error.
              2'b11: begin
                func_next[gi] = q_q[gi];
                sr_viol[gi]   = 1'b1;
              end
            endcase
          end
        endcase
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Next-state selection: load beats enable; reset handled in the register.
  // -------------------------------------------------------------------------
  always_comb begin
    q_d      = q_q;
    sr_err_d = sr_err_q;

    if (load) begin
      q_d = load_val;
    end else if (en) begin
      q_d = func_next;
    end

    if (clr_err) begin
      sr_err_d = 1'b0;
    end
    // A violation at the same edge as clr_err still leaves the flag set.
    if (!load && en && (mode_sel == MODE_SR) && (|sr_viol)) begin
      sr_err_d = 1'b1;
    end

    chg_d = (q_d != q_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q      <= '0;
      sr_err_q <= 1'b0;
      chg_q    <= 1'b0;
    end else begin
      q_q      <= q_d;
      sr_err_q <= sr_err_d;
      chg_q    <= chg_d;
    end
  end

  assign q      = q_q;
  assign qn     = ~q_q;
  assign sr_err = sr_err_q;
  assign chg    = chg_q;

  // -------------------------------------------------------------------------
  // Optional saturating change counter
  // -------------------------------------------------------------------------
`ifdef FF_CHG_CNT_EN
  logic [CNT_W-1:0] chg_cnt_q, chg_cnt_d;

  always_comb begin
    chg_cnt_d = chg_cnt_q;
    // Counts the same edges that raise chg; sticks at all-ones.
    if (chg_d && (chg_cnt_q != {CNT_W{1'b1}})) begin
      chg_cnt_d = chg_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chg_cnt_q <= '0;
    end else begin
      chg_cnt_q <= chg_cnt_d;
    end
  end

  assign chg_cnt = chg_cnt_q;
`else
  // Counter absent; CNT_W only has to describe a realisable width.
  generate
    if (CNT_W < 1) begin : g_cnt_w_invalid
    end
  endgenerate
`endif

endmodule

// File: tb/tb_ff_bank.sv
// ---------------------------------------------------------------------------
// tb_ff_bank -- self-checking bench for ff_bank (WIDTH=8, CNT_W=2).
// A behavioural model built from the flip-flop characteristic equations
// predicts q / sr_err / chg (and chg_cnt when FF_CHG_CNT_EN is defined);
// a compare process checks the DUT against it every cycle, and directed
// steps check hand-computed literal values.
// ---------------------------------------------------------------------------
module tb_ff_bank;

  localparam int W = 8;
  localparam int CW = 2;

  logic         clk = 1'b0;
  logic         rst, en, load, clr_err;
  logic [1:0]   mode;
  logic [W-1:0] a, b, load_val;
  logic [W-1:0] q, qn;
  logic         sr_err, chg;
`ifdef FF_CHG_CNT_EN
  logic [CW-1:0] chg_cnt;
`endif

  int assertions = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ff_bank #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
    .load(load), .load_val(load_val), .clr_err(clr_err),
    .q(q), .qn(qn), .sr_err(sr_err), .chg(chg)
`ifdef FF_CHG_CNT_EN
    , .chg_cnt(chg_cnt)
`endif
  );

  // ------------------------------- model -----------------------------------
  logic [W-1:0] m_q = '0;
  logic         m_err = 1'b0;
  logic         m_chg = 1'b0;
  int           m_cnt = 0;
  logic         started = 1'b0;

  // Characteristic equations of the four flip-flop types.
  function automatic logic [W-1:0] ff_eq(input logic [1:0] md, input logic [W-1:0] s,
                                         input logic [W-1:0] r, input logic [W-1:0] cur);
    case (md)
      2'b00:   return s;
      2'b01:   return cur ^ s;
      2'b10:   return (s & ~cur) | (~r & cur);
      default: return (s & ~r) | (cur & ~(s ^ r));
    endcase
  endfunction

  always @(posedge clk) begin
    logic [W-1:0] nxt;
    logic         err;
    nxt = load ? load_val : (en ? ff_eq(mode, a, b, m_q) : m_q);
    err = (m_err && !clr_err) || (!load && en && mode == 2'b11 && (a & b) != 0);
    if (rst) begin
      m_q <= '0; m_err <= 1'b0; m_chg <= 1'b0; m_cnt <= 0;
    end else begin
      m_q <= nxt;
      m_err <= err;
      m_chg <= (nxt != m_q);
      if (nxt != m_q) m_cnt <= (m_cnt + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_cnt + 1;
    end
    started <= 1'b1;
  end

  // --------------------------- compare process -----------------------------
  always @(negedge clk) begin
    if (started) begin
      assertions++;
      if (q !== m_q || qn !== ~m_q || sr_err !== m_err || chg !== m_chg) begin
        failures++;
        $display("FAIL model_cmp t=%0t: q=%h qn=%h sr_err=%b chg=%b, required q=%h qn=%h sr_err=%b chg=%b",
                 $time, q, qn, sr_err, chg, m_q, ~m_q, m_err, m_chg);
      end
`ifdef FF_CHG_CNT_EN
      assertions++;
      if (int'(chg_cnt) != m_cnt) begin
        failures++;
        $display("FAIL model_cnt t=%0t: chg_cnt=%0d required %0d", $time, chg_cnt, m_cnt);
      end
`endif
    end
  end

  // ------------------------------ helpers ----------------------------------
  task automatic apply(input logic r, input logic ld, input logic [W-1:0] lv,
                       input logic e, input logic [1:0] md, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic ce);
    rst = r; load = ld; load_val = lv; en = e; mode = md; a = av; b = bv; clr_err = ce;
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("txn rst=%b load=%b lv=%h en=%b mode=%b a=%h b=%h clr=%b -> q=%h sr_err=%b chg=%b",
             r, ld, lv, e, md, av, bv, ce, q, sr_err, chg);
  endtask

  task automatic expect_out(input string name, input logic [W-1:0] eq,
                            input logic ee, input logic ec);
    assertions++;
    if (q !== eq || qn !== ~eq || sr_err !== ee || chg !== ec) begin
      failures++;
      $display("FAIL %s: q=%h qn=%h sr_err=%b chg=%b, required q=%h qn=%h sr_err=%b chg=%b",
               name, q, qn, sr_err, chg, eq, ~eq, ee, ec);
    end
  endtask

  // ------------------------------ stimulus ---------------------------------
  initial begin
    rst = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; mode = 2'b00;
    a = '0; b = '0; clr_err = 1'b0;

    apply(1, 0, 8'h00, 0, 2'b00, 8'h00, 8'h00, 0);
    expect_out("reset", 8'h00, 0, 0);

    // JK set/clear then toggle
    apply(0, 0, 8'h00, 1, 2'b10, 8'hF0, 8'h0F, 0);
    expect_out("jk_set_clr", 8'hF0, 0, 1);
    apply(0, 0, 8'h00, 1, 2'b10, 8'hFF, 8'hFF, 0);
    expect_out("jk_toggle", 8'h0F, 0, 1);

    // SR with an invalid bit, then clear the error
    apply(0, 1, 8'h00, 0, 2'b00, 8'h00, 8'h00, 0);
    expect_out("load_zero", 8'h00, 0, 1);
    apply(0, 0, 8'h00, 1, 2'b11, 8'h81, 8'h01, 0);
    expect_out("sr_violation", 8'h80, 1, 1);
    apply(0, 0, 8'h00, 1, 2'b11, 8'h00, 8'h00, 1);
    expect_out("sr_clr_err", 8'h80, 0, 0);
    apply(0, 0, 8'h00, 1, 2'b11, 8'h01, 8'h01, 1);
    expect_out("sr_set_beats_clr", 8'h80, 1, 0);

    // Load beats T mode; reset beats load
    apply(0, 1, 8'hA5, 1, 2'b01, 8'hFF, 8'h00, 0);
    expect_out("load_over_en", 8'hA5, 1, 1);
    apply(1, 1, 8'hA5, 1, 2'b01, 8'hFF, 8'h00, 0);
    expect_out("rst_over_load", 8'h00, 0, 0);

    // Hold with en=0 and random inputs
    apply(0, 1, 8'h3C, 0, 2'b00, 8'h00, 8'h00, 0);
    expect_out("load_3c", 8'h3C, 0, 1);
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 8'h00, 0, 2'($urandom_range(3)), 8'($urandom), 8'($urandom), 0);
      expect_out("en0_hold", 8'h3C, 0, 0);
    end
    apply(0, 0, 8'h00, 1, 2'b01, 8'h00, 8'h00, 0);
    expect_out("t_zero_hold", 8'h3C, 0, 0);

    // D, T, redundant load, load during SR violation
    apply(0, 0, 8'h00, 1, 2'b00, 8'h5A, 8'hFF, 0);
    expect_out("d_mode", 8'h5A, 0, 1);
    apply(0, 0, 8'h00, 1, 2'b01, 8'h0F, 8'hFF, 0);
    expect_out("t_mode", 8'h55, 0, 1);
    apply(0, 1, 8'h55, 1, 2'b01, 8'hFF, 8'h00, 0);
    expect_out("load_same", 8'h55, 0, 0);
    apply(0, 1, 8'h12, 1, 2'b11, 8'hFF, 8'hFF, 0);
    expect_out("load_no_sr_err", 8'h12, 0, 1);

    // Reset in the middle of toggling, then resume with current inputs
    apply(0, 0, 8'h00, 1, 2'b01, 8'hFF, 8'h00, 0);
    expect_out("toggle_1", 8'hED, 0, 1);
    apply(1, 0, 8'h00, 1, 2'b01, 8'hFF, 8'h00, 0);
    expect_out("toggle_rst", 8'h00, 0, 0);
    apply(0, 0, 8'h00, 1, 2'b01, 8'hFF, 8'h00, 0);
    expect_out("toggle_after_rst", 8'hFF, 0, 1);

`ifdef FF_CHG_CNT_EN
    apply(1, 0, 8'h00, 0, 2'b00, 8'h00, 8'h00, 0);
    for (int i = 0; i < 5; i++) begin
      int exp_cnt;
      exp_cnt = (i + 1 > 3) ? 3 : i + 1;
      apply(0, 0, 8'h00, 1, 2'b01, 8'h01, 8'h00, 0);
      assertions++;
      if (int'(chg_cnt) != exp_cnt) begin
        failures++;
        $display("FAIL chg_cnt_sat: chg_cnt=%0d required %0d", chg_cnt, exp_cnt);
      end
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
